// File: rtl/eth_pkg.sv
// Shared types and constants for the egress port slice.
package eth_pkg;

  localparam int ETH_WORD_W  = 32;
  localparam int ETH_ENTRY_W = 34;

  // Buffer entry layout: {eop, sop, data}
  localparam int ENTRY_EOP_IDX  = 33;
  localparam int ENTRY_SOP_IDX  = 32;
  localparam int ENTRY_DATA_MSB = 31;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_BODY    = 2'd1,
    RX_DISCARD = 2'd2
  } rx_state_t;

  // Adds a small increment to a 16-bit counter, sticking at all-ones.
  function automatic logic [15:0] satAdd16(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/eth_pkt_buf.sv
// Packet buffer with separate speculative-write, committed-write and read
// pointers. Writes land at the write pointer; a rewind throws away the
// uncommitted tail, a commit publishes everything written so far to the reader.
module eth_pkt_buf
  import eth_pkg::*;
#(
  parameter int BUF_DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wrEn_i,
  input  logic [ETH_ENTRY_W-1:0] wrEntry_i,
  input  logic                   rewind_i,
  input  logic                   commit_i,
  input  logic                   rdEn_i,
  output logic [ETH_ENTRY_W-1:0] rdEntry_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   fullCommitted_o
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [ETH_ENTRY_W-1:0] mem [BUF_DEPTH];
  logic [AW:0] wrPtrQ, wrPtrD;
  logic [AW:0] cwPtrQ, cwPtrD;
  logic [AW:0] rdPtrQ, rdPtrD;
  logic [AW:0] wrBase;

  // A rewind and a write in the same cycle restart the packet at the committed pointer.
  always_comb begin
    wrBase = rewind_i ? cwPtrQ : wrPtrQ;
    wrPtrD = wrEn_i ? wrBase + PTR_ONE : wrBase;
    cwPtrD = commit_i ? wrPtrD : cwPtrQ;
    rdPtrD = rdEn_i ? rdPtrQ + PTR_ONE : rdPtrQ;
  end

  // Pointer registers; reset empties the buffer without touching storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtrQ <= '0;
      cwPtrQ <= '0;
      rdPtrQ <= '0;
    end else begin
      wrPtrQ <= wrPtrD;
      cwPtrQ <= cwPtrD;
      rdPtrQ <= rdPtrD;
    end
  end

  // Storage array, written at the (possibly rewound) write position.
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem[wrBase[AW-1:0]] <= wrEntry_i;
    end
  end

  assign rdEntry_o       = mem[rdPtrQ[AW-1:0]];
  assign empty_o         = (rdPtrQ == cwPtrQ);
  assign full_o          = (wrPtrQ[AW] != rdPtrQ[AW]) && (wrPtrQ[AW-1:0] == rdPtrQ[AW-1:0]);
  assign fullCommitted_o = (cwPtrQ[AW] != rdPtrQ[AW]) && (cwPtrQ[AW-1:0] == rdPtrQ[AW-1:0]);

endmodule

// File: rtl/eth_tx_port.sv
// Store-and-forward egress port: filters packets by destination address,
// buffers them whole, and only hands complete, accepted packets to the link.
module eth_tx_port
  import eth_pkg::*;
#(
  parameter logic [ETH_WORD_W-1:0] PORT_ADDR = 32'hABCD,
  parameter int                    BUF_DEPTH = 64,
  parameter int                    MAX_WORDS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ETH_WORD_W-1:0] inData,
  input  logic                  inSop,
  input  logic                  inEop,
  output logic [ETH_WORD_W-1:0] txData,
  output logic                  txSop,
  output logic                  txEop,
  output logic                  txValid,
  input  logic                  txReady,
  output logic [15:0]           pktCount,
  output logic [15:0]           dropCount
);

  localparam int LW = $clog2(MAX_WORDS + 1);
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_WORDS);
  localparam logic [LW-1:0] LEN_ONE = LW'(1);
  localparam logic [LW-1:0] LEN_TWO = LW'(2);

  rx_state_t stateQ, stateD;
  logic [LW-1:0] lenQ, lenD, lenNext;
  logic addrOkQ, addrOkD;
  logic [15:0] pktCountQ, dropCountQ;
  logic [1:0] dropInc;
  logic pktInc;

  logic bufWrEn, bufRewind, bufCommit, bufRdEn;
  logic bufEmpty, bufFull, bufFullCommitted;
  logic [ETH_ENTRY_W-1:0] bufRdEntry;

  logic [ETH_WORD_W-1:0] txDataQ;
  logic txSopQ, txEopQ, txValidQ;

  eth_pkt_buf #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk             (clk),
    .reset           (reset),
    .wrEn_i          (bufWrEn),
    .wrEntry_i       ({inEop, inSop, inData}),
    .rewind_i        (bufRewind),
    .commit_i        (bufCommit),
    .rdEn_i          (bufRdEn),
    .rdEntry_o       (bufRdEntry),
    .empty_o         (bufEmpty),
    .full_o          (bufFull),
    .fullCommitted_o (bufFullCommitted)
  );

  // Receive FSM: decides per input word whether to store, drop, restart or commit.
  always_comb begin
    stateD    = stateQ;
    lenD      = lenQ;
    addrOkD   = addrOkQ;
    bufWrEn   = 1'b0;
    bufRewind = 1'b0;
    bufCommit = 1'b0;
    dropInc   = 2'd0;
    pktInc    = 1'b0;
    lenNext   = lenQ + LEN_ONE;
    case (stateQ)
      RX_IDLE, RX_DISCARD: begin
        if (inSop) begin
          if (inEop) begin
            dropInc = 2'd1;
            stateD  = RX_IDLE;
          end else if (bufFullCommitted) begin
            dropInc = 2'd1;
            stateD  = RX_DISCARD;
          end else begin
            bufWrEn = 1'b1;
            lenD    = LEN_ONE;
            addrOkD = (inData == PORT_ADDR);
            stateD  = RX_BODY;
          end
        end else if (inEop) begin
          stateD = RX_IDLE;
        end
      end
      RX_BODY: begin
        if (inSop) begin
          // The packet in progress is abandoned; the new one may also be unusable.
          bufRewind = 1'b1;
          if (inEop) begin
            dropInc = 2'd2;
            stateD  = RX_IDLE;
          end else if (bufFullCommitted) begin
            dropInc = 2'd2;
            stateD  = RX_DISCARD;
          end else begin
            dropInc = 2'd1;
            bufWrEn = 1'b1;
            lenD    = LEN_ONE;
            addrOkD = (inData == PORT_ADDR);
          end
        end else if (lenQ >= MAX_LEN || bufFull) begin
          bufRewind = 1'b1;
          dropInc   = 2'd1;
          stateD    = inEop ? RX_IDLE : RX_DISCARD;
        end else if (inEop && !(addrOkQ && lenNext >= LEN_TWO)) begin
          bufRewind = 1'b1;
          dropInc   = 2'd1;
          stateD    = RX_IDLE;
        end else begin
          bufWrEn = 1'b1;
          lenD    = lenNext;
          if (inEop) begin
            bufCommit = 1'b1;
            pktInc    = 1'b1;
            stateD    = RX_IDLE;
          end
        end
      end
      default: stateD = RX_IDLE;
    endcase
  end

  // Receive state, packet length, address match flag and the two saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= RX_IDLE;
      lenQ       <= '0;
      addrOkQ    <= 1'b0;
      pktCountQ  <= '0;
      dropCountQ <= '0;
    end else begin
      stateQ     <= stateD;
      lenQ       <= lenD;
      addrOkQ    <= addrOkD;
      pktCountQ  <= satAdd16(pktCountQ, {1'b0, pktInc});
      dropCountQ <= satAdd16(dropCountQ, dropInc);
    end
  end

  // Pull the next committed word whenever the output stage is empty or being drained.
  assign bufRdEn = !bufEmpty && (!txValidQ || txReady);

  // Registered link-side output stage, held while the link stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      txValidQ <= 1'b0;
      txSopQ   <= 1'b0;
      txEopQ   <= 1'b0;
      txDataQ  <= '0;
    end else if (bufRdEn) begin
      txValidQ <= 1'b1;
      txSopQ   <= bufRdEntry[ENTRY_SOP_IDX];
      txEopQ   <= bufRdEntry[ENTRY_EOP_IDX];
      txDataQ  <= bufRdEntry[ENTRY_DATA_MSB:0];
    end else if (txReady) begin
      txValidQ <= 1'b0;
    end
  end

  assign txData    = txDataQ;
  assign txSop     = txSopQ;
  assign txEop     = txEopQ;
  assign txValid   = txValidQ;
  assign pktCount  = pktCountQ;
  assign dropCount = dropCountQ;

endmodule
